// File: rtl/repeated_add_multiplier.sv
// rtl/repeated_add_multiplier.sv - shift-free multiplier: accumulates A into P, B times, via a sliced ripple-carry adder
module rma_full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module rma_rca4_slice (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_ci,
    output logic [3:0] o_s,
    output logic       o_co
);
    logic [4:0] w_c;

    assign w_c[0] = i_ci;
    assign o_co   = w_c[4];

    for (genvar g = 0; g < 4; g++) begin : g_fa
        rma_full_adder u_fa (
            .i_a  (i_a[g]),
            .i_b  (i_b[g]),
            .i_ci (w_c[g]),
            .o_s  (o_s[g]),
            .o_co (w_c[g+1])
        );
    end
endmodule

module repeated_add_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] product,
    output logic             done,
    output logic             busy,
    output logic             overflow
);
    localparam int NSLICE = WIDTH / 4;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_ADD    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_p;
    logic             r_ovf;
    logic [WIDTH-1:0] w_sum;
    logic [NSLICE:0]  w_carry;
    logic             w_eqz;

    assign w_carry[0] = 1'b0;
    assign w_eqz      = (r_b == '0);

    for (genvar s = 0; s < NSLICE; s++) begin : g_slice
        rma_rca4_slice u_slice (
            .i_a  (r_p[4*s +: 4]),
            .i_b  (r_a[4*s +: 4]),
            .i_ci (w_carry[s]),
            .o_s  (w_sum[4*s +: 4]),
            .o_co (w_carry[s+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD_A;
            S_LOAD_A: w_next = S_LOAD_B;
            S_LOAD_B: w_next = S_ADD;
            S_ADD:    if (w_eqz) w_next = S_DONE;
            S_DONE:   if (!start) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // The final slice carry only feeds the sticky overflow flag, never the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_p   <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD_A: r_a <= data_in;
                S_LOAD_B: begin
                    r_b   <= data_in;
                    r_p   <= '0;
                    r_ovf <= 1'b0;
                end
                S_ADD: begin
                    if (!w_eqz) begin
                        r_p   <= w_sum;
                        r_b   <= r_b - ONE;
                        r_ovf <= r_ovf | w_carry[NSLICE];
                    end
                end
                default: ;
            endcase
        end
    end

    assign product  = r_p;
    assign overflow = r_ovf;
    assign done     = (r_state == S_DONE);
    assign busy     = (r_state == S_LOAD_A) || (r_state == S_LOAD_B) || (r_state == S_ADD);
endmodule

// File: tb/tb_repeated_add_multiplier.sv
// tb/tb_repeated_add_multiplier.sv - directed checks of product, latency, flags and reset behaviour
module tb_repeated_add_multiplier;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] data_in;
    logic [15:0] product;
    logic        done;
    logic        busy;
    logic        overflow;

    int n_checks;
    int n_fail;

    repeated_add_multiplier #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .product  (product),
        .done     (done),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs a*b; 'pulse' toggles start mid-ADD, 'abort' >0 pulls reset after that many ADD edges.
    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input bit pulse, input int abort,
                       input logic [15:0] exp_p, input logic exp_ovf);
        int k;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; data_in = a;
        check({tag, "_busy_loada"}, 32'(busy), 32'd1);
        @(negedge clk); data_in = b;
        @(negedge clk); data_in = 16'h0;
        check({tag, "_busy_add"}, 32'(busy), 32'd1);
        k = 0;
        while (!done && k < 70000) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            start = (pulse && k == 2);
            if (abort > 0 && k == abort) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_product"}, 32'(product), 32'd0);
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_done"}, 32'(done), 32'd0);
                check({tag, "_rst_ovf"}, 32'(overflow), 32'd0);
                @(negedge clk); rst_n = 1'b1;
                return;
            end
        end
        start = 1'b0;
        check({tag, "_cycles"}, 32'(k), 32'(b) + 32'd1);
        check({tag, "_product"}, 32'(product), 32'(exp_p));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    initial begin
        logic [15:0] held;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        data_in  = 16'h0;
        #12;
        check("reset_product", 32'(product), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", 32'(busy), 32'd0);

        run("m17x5", 16'd17, 16'd5, 1'b0, 0, 16'd85, 1'b0);
        run("m1234x0", 16'd1234, 16'd0, 1'b0, 0, 16'd0, 1'b0);
        run("m300x300", 16'd300, 16'd300, 1'b0, 0, 16'd24464, 1'b1);
        run("m0x7", 16'd0, 16'd7, 1'b0, 0, 16'd0, 1'b0);
        run("m100x50_abort", 16'd100, 16'd50, 1'b0, 10, 16'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("post_abort_idle", 32'(busy), 32'd0);
        check("post_abort_done", 32'(done), 32'd0);
        run("m7x6", 16'd7, 16'd6, 1'b0, 0, 16'd42, 1'b0);

        // Hold start through DONE, then release to IDLE.
        held  = product;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("hold_done", 32'(done), 32'd1);
        check("hold_product", 32'(product), 32'(held));
        start = 1'b0;
        @(negedge clk);
        check("release_done", 32'(done), 32'd0);
        check("release_busy", 32'(busy), 32'd0);
        check("release_product", 32'(product), 32'd42);

        run("m6x9_pulse", 16'd6, 16'd9, 1'b1, 0, 16'd54, 1'b0);
        run("m3x4", 16'd3, 16'd4, 1'b0, 0, 16'd12, 1'b0);
        run("m65535x1", 16'd65535, 16'd1, 1'b0, 0, 16'd65535, 1'b0);
        @(negedge clk);
        check("idle_product_kept", 32'(product), 32'd65535);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
